// File: rtl/nim_trig_pkg.sv
// Shared types, default sizes and helpers for the NIM trigger controller.
// Latency: none (package only); backpressure: not applicable.
package nim_trig_pkg;

  localparam int N_CH_DEF  = 8;
  localparam int CNT_W_DEF = 32;
  localparam int CFG_W_DEF = 16;
  localparam int TS_W      = 48;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    FIRE      = 3'd2,
    HOLDOFF   = 3'd3,
    WAIT_BUSY = 3'd4
  } state_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/nim_sat_counter.sv
// Saturating event counter; clear beats a same-cycle increment.
// Latency: count updates on the edge after inc; backpressure: none, holds at all-ones.
module nim_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/nim_trig_ctrl.sv
// Coincidence -> prescale -> veto/holdoff/busy gated one-cycle trigger, plus raw/accepted counters; NIM_TRIG_CTRL_TIMESTAMP_EN adds a trigger timestamp.
// Latency: ch_trig sampled at edge k -> trig_out high after edge k+2; backpressure: busy_in holds WAIT_BUSY, events meanwhile are counted raw only.
module nim_trig_ctrl
  import nim_trig_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CFG_W = CFG_W_DEF,
  localparam int MIN_W = $clog2(N_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cnt_clear,
  input  logic [N_CH-1:0]   ch_trig,
  input  logic [N_CH-1:0]   coinc_mask,
  input  logic [MIN_W-1:0]  coinc_min,
  input  logic [CFG_W-1:0]  prescale,
  input  logic [CFG_W-1:0]  holdoff,
  input  logic              ext_veto,
  input  logic              busy_in,
  output logic              trig_out,
  output logic              dead,
  output logic [CNT_W-1:0]  raw_count,
  output logic [CNT_W-1:0]  acc_count,
  output logic [2:0]        state_o,
  output logic [TS_W-1:0]   ts_out,
  output logic              ts_valid
);

  localparam logic [CFG_W-1:0] CFG_ONE = {{(CFG_W-1){1'b0}}, 1'b1};
  localparam logic [CFG_W:0]   PS_ONE  = {{CFG_W{1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [N_CH-1:0]    in_z, mask_sh;
  logic [MIN_W-1:0]   min_sh;
  logic [CFG_W-1:0]   ps_sh, ho_sh, pcnt, hcnt;
  logic               cond_now, cond_r, cond_z, qualified;
  logic               accept, fire_now;
  logic [CFG_W:0]     pcnt_inc, ps_eff;

  // Coincidence is registered once more so the accept decision lands two edges after sampling.
  assign cond_now  = (min_sh != '0) &&
                     (popcount(64'(in_z & mask_sh)) >= 32'(min_sh));
  assign qualified = cond_r & ~cond_z;

  assign pcnt_inc = {1'b0, pcnt} + PS_ONE;
  assign ps_eff   = (ps_sh == '0) ? PS_ONE : {1'b0, ps_sh};
  assign accept   = (state == ARMED) && enable && qualified && !ext_veto;
  assign fire_now = accept && (pcnt_inc >= ps_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    trig_out  = 1'b0;
    dead      = 1'b1;
    case (state)
      IDLE:      state_nxt = ARMED;
      ARMED: begin
        dead = 1'b0;
        if (fire_now) state_nxt = FIRE;
      end
      FIRE: begin
        trig_out  = 1'b1;
        state_nxt = (ho_sh != '0) ? HOLDOFF : WAIT_BUSY;
      end
      HOLDOFF:   if (hcnt == CFG_ONE) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!busy_in) state_nxt = ARMED;
      default:   state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_z    <= '0;
      cond_r  <= 1'b0;
      cond_z  <= 1'b0;
      mask_sh <= '0;
      min_sh  <= '0;
      ps_sh   <= '0;
      ho_sh   <= '0;
      pcnt    <= '0;
      hcnt    <= '0;
    end else begin
      in_z   <= ch_trig;
      cond_r <= cond_now;
      cond_z <= cond_r;
      // Config only follows the inputs while idle, so it is frozen once armed.
      if (state == IDLE) begin
        mask_sh <= coinc_mask;
        min_sh  <= coinc_min;
        ps_sh   <= prescale;
        ho_sh   <= holdoff;
        pcnt    <= '0;
      end
      if (accept) begin
        pcnt <= fire_now ? '0 : pcnt_inc[CFG_W-1:0];
      end
      if (state == FIRE) begin
        hcnt <= ho_sh;
      end else if (state == HOLDOFF) begin
        hcnt <= hcnt - CFG_ONE;
      end
    end
  end

  nim_sat_counter #(.W(CNT_W)) u_raw_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (qualified & enable),
    .clr   (cnt_clear),
    .count (raw_count)
  );

  nim_sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state == FIRE),
    .clr   (cnt_clear),
    .count (acc_count)
  );

`ifdef NIM_TRIG_CTRL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_out <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (state_nxt == FIRE) ts_out <= ts_cnt;
    end
  end

  assign ts_valid = trig_out;
`else
  assign ts_out   = '0;
  assign ts_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nim_trig_ctrl.sv
// Randomized bench for nim_trig_ctrl: a timestamp-level reference model queues expected trigger edges, a negedge monitor checks them.
// A second instance with 3-bit counters exercises saturation under the same stimulus.
module tb_nim_trig_ctrl;
  import nim_trig_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, cnt_clear, ext_veto, busy_in;
  logic [7:0]  ch_trig, coinc_mask;
  logic [3:0]  coinc_min;
  logic [15:0] prescale, holdoff;

  logic        trig_out, dead, ts_valid;
  logic [31:0] raw_count, acc_count;
  logic [2:0]  state_o;
  logic [47:0] ts_out;
  logic        trig_s, dead_s, ts_valid_s;
  logic [2:0]  raw_s, acc_s, state_s;
  logic [47:0] ts_out_s;

  always #5 clk = ~clk;

  nim_trig_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .cnt_clear(cnt_clear),
    .ch_trig(ch_trig), .coinc_mask(coinc_mask), .coinc_min(coinc_min),
    .prescale(prescale), .holdoff(holdoff), .ext_veto(ext_veto), .busy_in(busy_in),
    .trig_out(trig_out), .dead(dead), .raw_count(raw_count), .acc_count(acc_count),
    .state_o(state_o), .ts_out(ts_out), .ts_valid(ts_valid)
  );

  nim_trig_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .cnt_clear(cnt_clear),
    .ch_trig(ch_trig), .coinc_mask(coinc_mask), .coinc_min(coinc_min),
    .prescale(prescale), .holdoff(holdoff), .ext_veto(ext_veto), .busy_in(busy_in),
    .trig_out(trig_s), .dead(dead_s), .raw_count(raw_s), .acc_count(acc_s),
    .state_o(state_s), .ts_out(ts_out_s), .ts_valid(ts_valid_s)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: tracks edge index, arming time, last accepted edge and event totals.
  int     cyc = 0;
  bit     m_dis = 1'b1, m_wait = 1'b0;
  int     m_armed_since = 0, m_last_fire = -100, m_h = 0, m_pcnt = 0;
  longint m_raw = 0, m_acc = 0;
  bit     c1 = 0, c2 = 0, c3 = 0;
  int     exp_q[$];

  always @(posedge clk) begin
    bit co_now, qual;
    int ps_eff;
    cyc++;
    co_now = (coinc_min != 0) && ($countones(ch_trig & coinc_mask) >= coinc_min);
    qual   = c2 && !c3;
    ps_eff = (prescale == 0) ? 1 : int'(prescale);
    if (reset) begin
      m_dis = 1; m_wait = 0; m_pcnt = 0; m_raw = 0; m_acc = 0; m_last_fire = -100;
      c1 = 0; c2 = 0; c3 = 0;
      exp_q.delete();
    end else begin
      if (cnt_clear) m_acc = 0;
      else if (m_last_fire == cyc - 1) m_acc++;
      if (cnt_clear) m_raw = 0;
      else if (qual && enable) m_raw++;
      if (!enable) begin
        m_dis = 1; m_wait = 0; m_pcnt = 0;
      end else if (m_dis) begin
        m_dis = 0; m_armed_since = cyc; m_pcnt = 0;
      end else if (m_wait) begin
        if (cyc >= m_last_fire + m_h + 2 && !busy_in) begin
          m_wait = 0; m_armed_since = cyc;
        end
      end else if (m_armed_since < cyc && qual && !ext_veto) begin
        m_pcnt++;
        if (m_pcnt >= ps_eff) begin
          m_pcnt = 0; m_wait = 1; m_last_fire = cyc; m_h = int'(holdoff);
          exp_q.push_back(cyc);
        end
      end
      c3 = c2; c2 = c1; c1 = co_now;
    end
  end

  bit mon_on = 0;
  int last_trig_cyc = -1;

  always @(negedge clk) begin
    int es;
    bit exp_trig;
    if (mon_on) begin
      exp_trig = (m_last_fire == cyc);
      if (trig_out) begin
        last_trig_cyc = cyc;
        if (exp_q.size() == 0) chk("trig_unexpected", 1, 0);
        else chk("trig_edge", cyc, exp_q.pop_front());
      end
      if (m_dis) es = 0;
      else if (!m_wait) es = 1;
      else if (cyc == m_last_fire) es = 2;
      else if (cyc <= m_last_fire + m_h) es = 3;
      else es = 4;
      chk("state", state_o, es);
      chk("dead", dead, (m_dis || m_wait) ? 1 : 0);
      chk("raw", raw_count, sat(m_raw, 32));
      chk("acc", acc_count, sat(m_acc, 32));
      chk("trig_small", trig_s, exp_trig);
      chk("raw_small", raw_s, sat(m_raw, 3));
      chk("acc_small", acc_s, sat(m_acc, 3));
`ifdef NIM_TRIG_CTRL_TIMESTAMP_EN
      chk("ts_valid", ts_valid, exp_trig);
`else
      chk("ts_out_tied", ts_out, 0);
      chk("ts_valid_tied", ts_valid, 0);
`endif
    end
  end

  bit busy_auto = 0;
  int busy_len = 10, busy_left = 0;

  task automatic tick();
    @(negedge clk);
    if (busy_auto) begin
      if (trig_out) busy_left = busy_len;
      busy_in = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic set_cfg(input logic [7:0] m, input logic [3:0] mn,
                         input logic [15:0] ps, input logic [15:0] ho);
    enable = 0; ch_trig = 0; ext_veto = 0; cnt_clear = 0;
    repeat (3) tick();
    coinc_mask = m; coinc_min = mn; prescale = ps; holdoff = ho;
    repeat (2) tick();
    enable = 1;
    tick();
  endtask

  task automatic coinc(input logic [7:0] p, input int hold);
    ch_trig = p;
    repeat (hold) tick();
    ch_trig = 0;
  endtask

  task automatic do_clear();
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
  endtask

  initial begin
    int k;
    bit seen;
    reset = 1; enable = 0; cnt_clear = 0; ext_veto = 0; busy_in = 0;
    ch_trig = 0; coinc_mask = 0; coinc_min = 0; prescale = 0; holdoff = 0;
    tick();
    mon_on = 1;
    tick();
    reset = 0;

    // Basic fire and latency, then a long level giving one event
    set_cfg(8'h03, 4'd2, 16'd1, 16'd0);
    do_clear();
    k = cyc + 1;
    coinc(8'h03, 2);
    repeat (10) tick();
    chk("fire_latency", last_trig_cyc, k + 2);
    chk("fire_raw", raw_count, 1);
    chk("fire_acc", acc_count, 1);
    do_clear();
    coinc(8'h03, 15);
    repeat (5) tick();
    chk("level_raw", raw_count, 1);
    chk("level_acc", acc_count, 1);

    // Prescale 1-of-3
    set_cfg(8'h03, 4'd2, 16'd3, 16'd0);
    do_clear();
    repeat (9) begin
      coinc(8'h03, 2);
      repeat (18) tick();
    end
    chk("ps_raw", raw_count, 9);
    chk("ps_acc", acc_count, 3);
    chk("ps_raw_sat3", raw_s, 7);

    // Holdoff plus busy: events in the dead window are counted but not accepted
    set_cfg(8'h03, 4'd2, 16'd1, 16'd5);
    busy_auto = 1; busy_len = 10; busy_left = 0;
    do_clear();
    coinc(8'h03, 2);
    repeat (3) begin
      repeat (2) tick();
      coinc(8'h03, 1);
    end
    repeat (20) tick();
    chk("dead_raw", raw_count, 4);
    chk("dead_acc", acc_count, 1);
    busy_auto = 0; busy_in = 0;

    // Vetoed event leaves the prescale count alone
    set_cfg(8'h03, 4'd2, 16'd2, 16'd0);
    do_clear();
    ext_veto = 1;
    coinc(8'h03, 2);
    repeat (2) tick();
    ext_veto = 0;
    repeat (5) tick();
    chk("veto_raw", raw_count, 1);
    chk("veto_acc", acc_count, 0);
    coinc(8'h03, 2);
    repeat (8) tick();
    chk("veto_acc_after1", acc_count, 0);
    coinc(8'h03, 2);
    repeat (8) tick();
    chk("veto_acc_after2", acc_count, 1);
    chk("veto_raw_after2", raw_count, 3);

    // Enable dropped during holdoff
    set_cfg(8'h03, 4'd2, 16'd1, 16'd20);
    ch_trig = 8'h03;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (trig_out) begin
        seen = 1;
        break;
      end
    end
    chk("eh_fire_seen", seen, 1);
    ch_trig = 0;
    repeat (3) tick();
    chk("eh_in_holdoff", state_o, 3);
    enable = 0;
    tick();
    chk("eh_idle", state_o, 0);

    // coinc_min = 0 never fires
    set_cfg(8'hFF, 4'd0, 16'd1, 16'd0);
    do_clear();
    repeat (3) begin
      coinc(8'hFF, 3);
      repeat (5) tick();
    end
    chk("min0_raw", raw_count, 0);
    chk("min0_acc", acc_count, 0);

    // Clear on the same edge as a raw increment
    set_cfg(8'h03, 4'd2, 16'd1, 16'd0);
    do_clear();
    ch_trig = 8'h03;
    repeat (2) tick();
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    ch_trig = 0;
    repeat (3) tick();
    chk("clr_raw", raw_count, 0);
    chk("clr_acc", acc_count, 1);

    // Randomized episodes, one with a mid-run reset
    for (int ep = 0; ep < 40; ep++) begin
      busy_auto = 0; busy_in = 0; busy_left = 0;
      set_cfg(8'($urandom), 4'($urandom_range(0, 4)), 16'($urandom_range(0, 4)),
              16'($urandom_range(0, 6)));
      busy_auto = 1'($urandom_range(0, 1));
      busy_len  = $urandom_range(0, 8);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 3) == 0) ch_trig = 8'($urandom);
        ext_veto  = ($urandom_range(0, 9) == 0);
        cnt_clear = ($urandom_range(0, 29) == 0);
        enable    = ($urandom_range(0, 49) != 0);
        if (!busy_auto) busy_in = ($urandom_range(0, 4) == 0);
        tick();
      end
      if (ep == 20) begin
        reset = 1;
        repeat (2) tick();
        reset = 0;
      end
    end

    // Mid-operation reset restores reset values
    busy_auto = 0; busy_in = 0;
    set_cfg(8'h03, 4'd2, 16'd1, 16'd8);
    coinc(8'h03, 4);
    reset = 1;
    tick();
    chk("rst_state", state_o, 0);
    chk("rst_dead", dead, 1);
    chk("rst_trig", trig_out, 0);
    chk("rst_raw", raw_count, 0);
    chk("rst_acc", acc_count, 0);
    reset = 0;
    enable = 0;
    repeat (5) tick();

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
